// File: rtl/tdm_demux.sv
// De-interleaves a round-robin TDM word stream into NUM_CH per-channel show-ahead FIFOs.
// Frame alignment follows a slot-0 marker delayed by ALIGN_DELAY cycles.
module tdm_demux #(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_CH      = 2,
   parameter int ALIGN_DELAY = 0,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        din,
   input  logic                         din_valid,
   input  logic                         din_sof,
   input  logic                         err_clr,
   output logic [NUM_CH*DATA_WIDTH-1:0] dout,
   output logic [NUM_CH-1:0]            dout_valid,
   input  logic [NUM_CH-1:0]            dout_ready,
   output logic                         locked,
   output logic [NUM_CH-1:0]            overflow,
   output logic                         sync_err
);

   localparam int SLOT_W = $clog2(NUM_CH);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t                  state;
   logic [SLOT_W-1:0]       slot;
   logic [SLOT_W-1:0]       ch;
   logic [SLOT_W-1:0]       next_slot;
   logic                    sof_d;
   logic                    push;
   logic [DATA_WIDTH-1:0]   mem [NUM_CH][FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr [NUM_CH];
   logic [PTR_W-1:0]        rd_ptr [NUM_CH];
   logic [CNT_W-1:0]        cnt [NUM_CH];
   logic [NUM_CH-1:0]       pop;
   logic [NUM_CH-1:0]       full;
   logic [NUM_CH-1:0]       accept;
   logic [NUM_CH-1:0]       drop;

   generate
      if (ALIGN_DELAY == 0) begin : g_no_delay
         assign sof_d = din_sof;
      end else begin : g_delay
         logic [ALIGN_DELAY-1:0] sof_pipe;
         always_ff @(posedge clk) begin
            if (rst) begin
               sof_pipe <= '0;
            end else begin
               sof_pipe[0] <= din_sof;
               for (int i = 1; i < ALIGN_DELAY; i++) begin
                  sof_pipe[i] <= sof_pipe[i-1];
               end
            end
         end
         assign sof_d = sof_pipe[ALIGN_DELAY-1];
      end
   endgenerate

   // A marker always forces slot 0, which both acquires lock and realigns a locked stream.
   always_comb begin
      ch        = sof_d ? '0 : slot;
      next_slot = (ch == SLOT_W'(NUM_CH - 1)) ? '0 : ch + SLOT_W'(1);
      push      = din_valid && ((state == LOCKED) || sof_d);
      pop       = '0;
      full      = '0;
      accept    = '0;
      drop      = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         pop[c]    = (cnt[c] != '0) && dout_ready[c];
         full[c]   = (cnt[c] == CNT_W'(FIFO_DEPTH));
         accept[c] = push && (ch == SLOT_W'(c)) && (!full[c] || pop[c]);
         drop[c]   = push && (ch == SLOT_W'(c)) && full[c] && !pop[c];
      end
   end

   always_comb begin
      dout       = '0;
      dout_valid = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         dout_valid[c]                        = (cnt[c] != '0);
         dout[c*DATA_WIDTH +: DATA_WIDTH]     = mem[c][rd_ptr[c]];
      end
   end

   assign locked = (state == LOCKED);

   // Storage is cleared on reset so an empty channel reads back zero until first written.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= HUNT;
         slot     <= '0;
         sync_err <= 1'b0;
         overflow <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            cnt[c]    <= '0;
            for (int d = 0; d < FIFO_DEPTH; d++) begin
               mem[c][d] <= '0;
            end
         end
      end else begin
         if (push) begin
            slot <= next_slot;
         end
         if ((state == HUNT) && din_valid && sof_d) begin
            state <= LOCKED;
         end
         if ((state == LOCKED) && din_valid && sof_d && (slot != '0)) begin
            sync_err <= 1'b1;
         end else if (err_clr) begin
            sync_err <= 1'b0;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (accept[c]) begin
               mem[c][wr_ptr[c]] <= din;
               wr_ptr[c]         <= wr_ptr[c] + PTR_W'(1);
            end
            if (pop[c]) begin
               rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
            end
            if (accept[c] && !pop[c]) begin
               cnt[c] <= cnt[c] + CNT_W'(1);
            end else if (!accept[c] && pop[c]) begin
               cnt[c] <= cnt[c] - CNT_W'(1);
            end
            if (drop[c]) begin
               overflow[c] <= 1'b1;
            end else if (err_clr) begin
               overflow[c] <= 1'b0;
            end
         end
      end
   end

endmodule
